// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      FETCH = 1'b0,
      FLUSH = 1'b1
   } fetch_state_e;

   // Clears the byte-offset bits so every fetch address is word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'(INSTR_BYTES - 1);
   endfunction

endpackage

// File: rtl/defines.sv
// Project-wide defaults shared by the fetch front end.
`ifndef RESET_VECTOR
`define RESET_VECTOR 32'h0000_0000
`endif

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push/pop/flush; head entry is read combinationally.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = fetch_entry_t,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  T              wdata,
   input  logic          pop,
   input  logic          flush,
   output T              rdata,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   T              mem [DEPTH];
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] wrPtr;
   logic          doPush;
   logic          doPop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   assign doPop  = pop && !empty;
   // A push into a full FIFO is only accepted when the head leaves in the same cycle.
   assign doPush = push && (!full || doPop);
   assign rdata  = mem[rdPtr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= ptr_inc(wrPtr);
         if (doPop)  rdPtr <= ptr_inc(rdPtr);
         if (doPush && !doPop)      count <= count + 1'b1;
         else if (doPop && !doPush) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush && !flush) mem[wrPtr] <= wdata;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (reset || flush)
      !(push && full && !pop));

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads under a credit limit and buffers returned words for decode.
`ifndef RESET_VECTOR
`define RESET_VECTOR 32'h0000_0000
`endif

module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = `RESET_VECTOR,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemGnt,
   input  logic        imemRValid,
   input  logic [31:0] imemRData,
   input  logic        redirect,
   input  logic [31:0] redirectPc,
   output logic        instrValid,
   output logic [31:0] instrCode,
   output logic [31:0] instrPc,
   input  logic        instrReady
);

   localparam int CW = $clog2(DEPTH + 1);

   fetch_state_e  state;
   fetch_state_e  stateNext;
   logic [31:0]   pc;
   logic [31:0]   pcNext;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] count;
   logic [CW-1:0] dropCnt;
   logic [CW-1:0] dropNext;
   logic [CW:0]   credit;
   logic          issue;
   logic          respValid;
   logic          bufPush;
   logic          bufPop;
   logic          tagFull;
   logic          tagEmpty;
   logic          bufFull;
   logic          bufEmpty;
   logic [31:0]   tagPc;
   fetch_entry_t  bufIn;
   fetch_entry_t  bufHead;

   assign credit    = {1'b0, outstanding} + {1'b0, count};
   assign imemReq   = !reset && (state == FETCH) && !redirect && (credit < (CW+1)'(DEPTH));
   assign imemAddr  = pc;
   assign issue     = imemReq && imemGnt;

   // Responses with nothing outstanding are ignored rather than corrupting the tag queue.
   assign respValid = imemRValid && !tagEmpty;
   assign bufPush   = respValid && (dropCnt == '0) && !redirect;
   assign bufIn     = '{pc: tagPc, instr: imemRData};

   assign instrValid = !bufEmpty && (state == FETCH);
   assign instrCode  = instrValid ? bufHead.instr : '0;
   assign instrPc    = instrValid ? bufHead.pc    : '0;
   assign bufPop     = instrValid && instrReady && !redirect;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (logic [31:0])
   ) u_tag_q (
      .clk   (clk),
      .reset (reset),
      .push  (issue),
      .wdata (pc),
      .pop   (respValid),
      .flush (1'b0),
      .rdata (tagPc),
      .count (outstanding),
      .full  (tagFull),
      .empty (tagEmpty)
   );

   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (fetch_entry_t)
   ) u_instr_buf (
      .clk   (clk),
      .reset (reset),
      .push  (bufPush),
      .wdata (bufIn),
      .pop   (bufPop),
      .flush (redirect),
      .rdata (bufHead),
      .count (count),
      .full  (bufFull),
      .empty (bufEmpty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FETCH;
         pc      <= word_align(RESET_PC);
         dropCnt <= '0;
      end else begin
         state   <= stateNext;
         pc      <= pcNext;
         dropCnt <= dropNext;
      end
   end

   always_comb begin
      pcNext    = pc;
      dropNext  = dropCnt;
      stateNext = state;
      if (redirect) begin
         // Everything still in flight belongs to the abandoned path, except a word returning right now.
         pcNext   = word_align(redirectPc);
         dropNext = outstanding - CW'(respValid);
      end else begin
         if (issue) pcNext = pc + 32'(INSTR_BYTES);
         if (respValid && (dropCnt != '0)) dropNext = dropCnt - 1'b1;
      end
      case (state)
         FETCH:   if (dropNext != '0) stateNext = FLUSH;
         FLUSH:   if (dropNext == '0) stateNext = FETCH;
         default: stateNext = FETCH;
      endcase
   end

   a_resp_tracked: assert property (@(posedge clk) disable iff (reset)
      !(imemRValid && tagEmpty));
   a_tag_credit: assert property (@(posedge clk) disable iff (reset)
      !(issue && tagFull));
   a_buf_credit: assert property (@(posedge clk) disable iff (reset)
      !(bufPush && bufFull && !bufPop));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: in-order memory responder plus program-order reference stream.
module tb_inst_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemGnt = 1'b0;
   logic        imemRValid = 1'b0;
   logic [31:0] imemRData = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirectPc = 32'h0;
   logic        instrValid;
   logic [31:0] instrCode;
   logic [31:0] instrPc;
   logic        instrReady = 1'b0;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   int           lastDue = 0;
   int           latMin = 1;
   int           latMax = 1;
   int           grants = 0;
   int           firstGrant = -1;
   int           firstValid = -1;
   req_t         memQ[$];
   fetch_entry_t expQ[$];
   logic [31:0]  expAddr = RST_PC;
   logic [31:0]  stallAddr = 32'h0;
   bit           stalled = 1'b0;
   bit           rstSeen = 1'b0;

   inst_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .imemReq    (imemReq),
      .imemAddr   (imemAddr),
      .imemGnt    (imemGnt),
      .imemRValid (imemRValid),
      .imemRData  (imemRData),
      .redirect   (redirect),
      .redirectPc (redirectPc),
      .instrValid (instrValid),
      .instrCode  (instrCode),
      .instrPc    (instrPc),
      .instrReady (instrReady)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: compares outputs against the reference stream and feeds the memory model.
   always @(negedge clk) begin
      if (reset) begin
         if (rstSeen) begin
            check("reset_req", 32'(imemReq), 32'd0);
            check("reset_valid", 32'(instrValid), 32'd0);
            check("reset_code", instrCode, 32'h0);
            check("reset_pc", instrPc, 32'h0);
         end
         expQ.delete();
         expAddr    = RST_PC;
         stalled    = 1'b0;
         grants     = 0;
         firstGrant = -1;
         firstValid = -1;
      end else begin
         if (!instrValid) begin
            check("idle_code", instrCode, 32'h0);
            check("idle_pc", instrPc, 32'h0);
         end else if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_instr: got pc %h code %h, expected none (cycle %0d)", instrPc, instrCode, cyc);
         end else begin
            check("instr_pc", instrPc, expQ[0].pc);
            check("instr_code", instrCode, expQ[0].instr);
         end
         if (instrValid && firstValid < 0) firstValid = cyc;
         if (redirect) check("redirect_req", 32'(imemReq), 32'd0);
         if (stalled && !redirect) begin
            check("stall_hold_req", 32'(imemReq), 32'd1);
            check("stall_hold_addr", imemAddr, stallAddr);
         end
         if (imemReq && imemGnt) begin
            int due;
            check("grant_addr", imemAddr, expAddr);
            expQ.push_back('{pc: expAddr, instr: memword(expAddr)});
            due = cyc + $urandom_range(latMax, latMin);
            if (due <= lastDue) due = lastDue + 1;
            lastDue = due;
            memQ.push_back('{addr: imemAddr, due: due});
            expAddr = expAddr + 32'd4;
            grants++;
            if (firstGrant < 0) firstGrant = cyc;
         end
         if (instrValid && instrReady && !redirect && expQ.size() > 0) void'(expQ.pop_front());
         if (redirect) begin
            expQ.delete();
            expAddr = redirectPc & 32'hFFFF_FFFC;
         end
         stalled   = imemReq && !imemGnt;
         stallAddr = imemAddr;
      end
      rstSeen = reset;
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (memQ.size() > 0 && memQ[0].due <= cyc) begin
         imemRValid = 1'b1;
         imemRData  = memword(memQ[0].addr);
         void'(memQ.pop_front());
      end else begin
         imemRValid = 1'b0;
         imemRData  = 32'hDEAD_BEEF;
      end
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      redirect   = 1'b0;
      imemRValid = 1'b0;
      memQ.delete();
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      do_reset();

      // Straight-line fetch, single-cycle memory.
      imemGnt = 1'b1; instrReady = 1'b1; latMin = 1; latMax = 1;
      repeat (12) step();
      check("first_valid_latency", 32'(firstValid - firstGrant), 32'd2);

      // Decode never ready: credit stops at DEPTH grants.
      do_reset();
      imemGnt = 1'b1; instrReady = 1'b0;
      repeat (10) step();
      check("credit_grants", 32'(grants), 32'd2);
      check("credit_req_low", 32'(imemReq), 32'd0);
      check("credit_valid", 32'(instrValid), 32'd1);
      check("credit_head_pc", instrPc, 32'h0);
      check("credit_head_code", instrCode, memword(32'h0));

      // Grant withheld: request and address held.
      do_reset();
      imemGnt = 1'b0; instrReady = 1'b1;
      repeat (3) begin
         step();
         check("nogrant_req", 32'(imemReq), 32'd1);
         check("nogrant_addr", imemAddr, 32'h0);
      end
      imemGnt = 1'b1;
      step();
      check("after_grant_addr", imemAddr, 32'h4);

      // Redirect with two words in flight.
      do_reset();
      imemGnt = 1'b1; instrReady = 1'b1; latMin = 3; latMax = 3;
      step();
      step();
      imemGnt = 1'b0; redirect = 1'b1; redirectPc = 32'h0000_0103;
      step();
      redirect = 1'b0;
      check("redirect_addr", imemAddr, 32'h100);
      check("flush_req", 32'(imemReq), 32'd0);
      check("flush_valid", 32'(instrValid), 32'd0);
      imemGnt = 1'b1;
      repeat (12) step();

      // Redirect during steady streaming (response + pop same cycle), wrapping at top of memory.
      latMin = 1; latMax = 1;
      repeat (4) step();
      redirect = 1'b1; redirectPc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      check("wrap_addr", imemAddr, 32'hFFFF_FFFC);
      repeat (8) step();

      // Reset in the middle of a flush.
      latMin = 4; latMax = 4;
      do_reset();
      imemGnt = 1'b1;
      step();
      step();
      redirect = 1'b1; redirectPc = 32'h0000_0200;
      step();
      redirect = 1'b0;
      reset = 1'b1; imemRValid = 1'b0; memQ.delete();
      step();
      check("midflush_rst_addr", imemAddr, RST_PC);
      check("midflush_rst_valid", 32'(instrValid), 32'd0);
      step();
      reset = 1'b0;
      latMin = 1; latMax = 1;
      repeat (8) step();

      // Randomized traffic.
      latMin = 1; latMax = 4;
      for (int i = 0; i < 3000; i++) begin
         imemGnt    = ($urandom_range(0, 3) != 0);
         instrReady = ($urandom_range(0, 2) != 0);
         redirect   = ($urandom_range(0, 24) == 0);
         redirectPc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
         step();
         if ($urandom_range(0, 499) == 0) do_reset();
      end

      // Drain: no new grants, everything already issued must reach decode.
      redirect = 1'b0; imemGnt = 1'b0; instrReady = 1'b1;
      for (int i = 0; i < 60 && expQ.size() > 0; i++) step();
      check("drain_left", 32'(expQ.size()), 32'd0);
      step();
      check("drain_valid", 32'(instrValid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
